hazard_ctrl: RTL

- Pipeline hazard and redirect controller for the 5-stage RISC-V core.
- Generates the PC write-enable and branch/jump select strobes consumed by the PC select register, plus the IF/ID and ID/EX write/flush controls.
- Handles three cases: load-use interlocks, multi-cycle data-memory waits, and post-redirect flush bubbles.
- Sits between the ID/EX stage decode signals and the fetch logic.

---
 rtl/hazard_ctrl_if.sv | 37 +++
 rtl/hazard_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// Bundle between the ID/EX decode signals, fetch logic and the hazard controller.
interface hazard_ctrl_if;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic [4:0] ex_rd;
    logic       ex_mem_read;
    logic       ex_branch_taken;
    logic       ex_jump;
    logic       dmem_busy;

    logic       pc_write;
    logic       beq_pc_sel;
    logic       jump_pc_sel;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       mem_timeout;
    logic [1:0] state;

    // Pipeline side: drives decode/memory status, consumes controls.
    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd,
               ex_mem_read, ex_branch_taken, ex_jump, dmem_busy,
        input  pc_write, beq_pc_sel, jump_pc_sel, if_id_write,
               if_id_flush, id_ex_flush, mem_timeout, state
    );

    // Controller side.
    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd,
               ex_mem_read, ex_branch_taken, ex_jump, dmem_busy,
        output pc_write, beq_pc_sel, jump_pc_sel, if_id_write,
               if_id_flush, id_ex_flush, mem_timeout, state
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use / memory-wait / redirect-flush controller for the 5-stage core.
// Define HAZARD_PERF_CNT_EN to add load-use stall and redirect counters.
module hazard_ctrl #(
    parameter int unsigned FLUSH_DEPTH  = 1,
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]   lu_stall_cnt,
    output logic [31:0]   redirect_cnt
`endif
);

    localparam int unsigned WAIT_W = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX   = WAIT_W'(MEM_WAIT_MAX);
    localparam logic [2:0]        FLUSH_INIT = 3'(FLUSH_DEPTH);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_e;

    state_e            state_q, state_d;
    state_e            ret_state_q, ret_state_d;
    logic [2:0]        flush_cnt_q, flush_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;

    logic   redirect;
    logic   load_use;
    logic   resume;
    state_e eval_state;

    logic pc_write_c, beq_pc_sel_c, jump_pc_sel_c;
    logic if_id_write_c, if_id_flush_c, id_ex_flush_c;

    assign redirect = hz.ex_branch_taken | hz.ex_jump;
    assign load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                      ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                       (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));

    // Leaving MEM_WAIT: behave exactly as the interrupted state would this cycle.
    assign resume     = (state_q == ST_MEM_WAIT) && !hz.dmem_busy;
    assign eval_state = resume ? ret_state_q : state_q;

    // State register
    always_ff @(posedge clk) begin
        state_q       <= state_d;
        ret_state_q   <= ret_state_d;
        flush_cnt_q   <= flush_cnt_d;
        wait_cnt_q    <= wait_cnt_d;
        mem_timeout_q <= mem_timeout_d;
    end

    // Next-state logic
    always_comb begin
        state_d       = state_q;
        ret_state_d   = ret_state_q;
        flush_cnt_d   = flush_cnt_q;
        wait_cnt_d    = resume ? '0 : wait_cnt_q;
        mem_timeout_d = mem_timeout_q;

        if (reset) begin
            state_d       = ST_RUN;
            ret_state_d   = ST_RUN;
            flush_cnt_d   = 3'd0;
            wait_cnt_d    = '0;
            mem_timeout_d = 1'b0;
        end else begin
            unique case (eval_state)
                ST_RUN: begin
                    state_d = ST_RUN;
                    if (hz.dmem_busy) begin
                        ret_state_d = ST_RUN;
                        state_d     = ST_MEM_WAIT;
                        wait_cnt_d  = WAIT_W'(1);
                    end else if (redirect && (FLUSH_DEPTH > 0)) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FLUSH_INIT;
                    end
                end
                ST_FLUSH: begin
                    if (hz.dmem_busy) begin
                        ret_state_d = ST_FLUSH;
                        state_d     = ST_MEM_WAIT;
                        wait_cnt_d  = WAIT_W'(1);
                    end else if (flush_cnt_q <= 3'd1) begin
                        state_d     = ST_RUN;
                        flush_cnt_d = 3'd0;
                    end else begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = flush_cnt_q - 3'd1;
                    end
                end
                ST_MEM_WAIT: begin
                    wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? WAIT_MAX : wait_cnt_q + WAIT_W'(1);
                end
                default: state_d = ST_RUN;
            endcase

            if ((state_d == ST_MEM_WAIT) && (wait_cnt_d == WAIT_MAX))
                mem_timeout_d = 1'b1;
        end
    end

    // Output logic
    always_comb begin
        pc_write_c    = 1'b0;
        beq_pc_sel_c  = 1'b0;
        jump_pc_sel_c = 1'b0;
        if_id_write_c = 1'b0;
        if_id_flush_c = 1'b0;
        id_ex_flush_c = 1'b0;

        if (reset) begin
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
        end else begin
            unique case (eval_state)
                ST_RUN: begin
                    if (hz.dmem_busy) begin
                        pc_write_c = 1'b0;
                    end else if (redirect) begin
                        // ID holds a wrong-path instruction, so any load-use match is moot.
                        pc_write_c    = 1'b1;
                        if_id_write_c = 1'b1;
                        beq_pc_sel_c  = hz.ex_branch_taken;
                        jump_pc_sel_c = hz.ex_jump & ~hz.ex_branch_taken;
                        if_id_flush_c = 1'b1;
                        id_ex_flush_c = 1'b1;
                    end else if (load_use) begin
                        id_ex_flush_c = 1'b1;
                    end else begin
                        pc_write_c    = 1'b1;
                        if_id_write_c = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (!hz.dmem_busy) begin
                        pc_write_c    = 1'b1;
                        if_id_write_c = 1'b1;
                        if_id_flush_c = 1'b1;
                        id_ex_flush_c = 1'b1;
                    end
                end
                ST_MEM_WAIT: pc_write_c = 1'b0;
                default: begin
                    if_id_flush_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                end
            endcase
        end
    end

    assign hz.pc_write    = pc_write_c;
    assign hz.beq_pc_sel  = beq_pc_sel_c;
    assign hz.jump_pc_sel = jump_pc_sel_c;
    assign hz.if_id_write = if_id_write_c;
    assign hz.if_id_flush = if_id_flush_c;
    assign hz.id_ex_flush = id_ex_flush_c;
    assign hz.mem_timeout = mem_timeout_q;
    assign hz.state       = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic lu_stall_inc;
    logic redirect_inc;

    assign lu_stall_inc = !reset && (eval_state == ST_RUN) && !hz.dmem_busy && !redirect && load_use;
    assign redirect_inc = !reset && (eval_state == ST_RUN) && !hz.dmem_busy && redirect;

    // Free-running event counters, wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            lu_stall_cnt <= 32'd0;
            redirect_cnt <= 32'd0;
        end else begin
            lu_stall_cnt <= lu_stall_cnt + 32'(lu_stall_inc);
            redirect_cnt <= redirect_cnt + 32'(redirect_inc);
        end
    end
`endif

endmodule
